adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Capture sequencer for the AD9054A interface block. On a start command it programs the demux mode, issues a DS synchronisation pulse, waits out a settling interval, then gates a programmed number of ADC samples onto an AXI-Stream master through a small elastic FIFO. It marks the final beat with tlast and reports completion and overflow status. It sits between the ADC interface's sample output and the downstream stream consumer, in the aclk domain.

## Interface
- DATA_W, 16, sample word width (combined da/db word from the ADC interface)
- CNT_W, 16, width of the sample-count register
- SYNC_LEN, 4, ds pulse length in aclk cycles (≥1)
- SETTLE_CYC, 32, settling cycles after ds falls (≥1)
- FIFO_DEPTH, 4, elastic FIFO entries (power of two, ≥2)

- aclk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle capture request
- abort  in  1  single-cycle cancel request
- demux_cfg  in  1  demux mode to apply for the capture
- num_samples  in  CNT_W  samples to deliver; 0 = request ignored
- demux  out  1  demux control to ADC interface
- ds  out  1  data-sync pulse to ADC interface
- s_tdata  in  DATA_W  sample from ADC interface
- s_tvalid  in  1  sample strobe; no backpressure possible
- m_axis_tdata  out  DATA_W  output sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final sample of capture
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on normal completion
- overflow  out  1  sticky: ≥1 sample dropped this capture

## Operation
- States: IDLE, SYNC, SETTLE, CAPTURE, DRAIN.
- Reset: state IDLE; demux, ds, m_axis_tvalid, m_axis_tlast, busy, done, overflow = 0; m_axis_tdata = 0; FIFO empty; counters 0.
- IDLE: start with num_samples≠0 → latch demux_cfg into demux, latch num_samples into remaining counter, clear overflow, go SYNC. start with num_samples=0 ignored. demux holds its last value in IDLE.
- SYNC: ds=1 for exactly SYNC_LEN cycles → SETTLE.
- SETTLE: ds=0; s_tvalid ignored; SETTLE_CYC cycles → CAPTURE.
- CAPTURE: each s_tvalid pushes s_tdata into the FIFO and decrements remaining. The push that takes remaining from 1 to 0 is tagged last, and the state goes to DRAIN the next cycle.
- FIFO full at push: sample dropped, overflow set, remaining not decremented. A push and a pop in the same cycle while full are both accepted, with no overflow.
- DRAIN: s_tvalid ignored; on handshake of the tagged beat (tvalid&tready&tlast), done=1 for the next cycle → IDLE.
- start while busy: ignored.
- abort in any non-IDLE state: next cycle state IDLE, FIFO flushed, ds=0, m_axis_tvalid=0, no done pulse, overflow keeps its value. abort in IDLE: no effect. abort and start in the same cycle: abort wins and start is ignored.
- AXI rules: outside abort, tvalid never drops before handshake; tdata/tlast stable while tvalid&!tready.
- Counter arithmetic is unsigned CNT_W, with no wrap because decrement is gated at remaining=0.

## Timing
- start sampled at edge 0 → busy=1 and ds=1 from edge 1; ds high edges 1..SYNC_LEN.
- SETTLE occupies the next SETTLE_CYC cycles. The first s_tvalid is accepted at edge 1+SYNC_LEN+SETTLE_CYC.
- FIFO latency: sample accepted at edge t → m_axis_tvalid=1 from edge t+1 if the FIFO was empty.
- done is high the cycle after the final handshake; busy falls in that same cycle.
- Throughput: one beat per cycle with tready held high.

## Test plan
- Reset mid-CAPTURE (assert rst asynchronously) → all outputs 0 immediately, FIFO empty, the next start behaves as from power-up.
- start, num_samples=8, demux_cfg=1, SYNC_LEN=4, SETTLE_CYC=32, tready=1, s_tvalid every cycle with values 1..N → demux=1, ds high 4 cycles, exactly 8 beats 1..8 (SETTLE-phase samples discarded), tlast on beat 8, done one cycle later, overflow=0.
- Same as above with tready=0 for 10 cycles during CAPTURE → first 4 samples buffered, later ones dropped, overflow=1. Output still totals 8 beats ending with tlast, and tdata holds stable while stalled.
- start with num_samples=0 → busy stays 0, ds stays 0, no output.
- abort 3 cycles into CAPTURE with 2 beats pending → next cycle tvalid=0 and busy=0, no done. A second start while in CAPTURE is ignored.
- num_samples=1 with full-rate input → single beat with tlast=1 and done pulse. FIFO full plus simultaneous pop while full → no overflow.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the AD9054A interface: demux setup, DS sync pulse,
// settling wait, then a counted burst of samples onto AXI-Stream via an elastic FIFO.
module adc_capture_ctrl #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int SYNC_LEN   = 4,
  parameter int SETTLE_CYC = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              demux_cfg,
  input  logic [CNT_W-1:0]  num_samples,
  output logic              demux,
  output logic              ds,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [2:0]        state_dbg
);

  // Stream handshake: a beat transfers on a rising edge where m_axis_tvalid and
  // m_axis_tready are both high; once raised, tvalid/tdata/tlast hold until then
  // (only abort or reset may withdraw a beat).

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       tmr;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  logic fifo_empty, fifo_full;
  logic pop, push_req, push, drop, last_push, accept, flush;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign push_req   = (state == CAPTURE) && s_tvalid && (remaining != '0);
  // A full FIFO still takes a sample when a beat leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign last_push  = push && (remaining == CNT_W'(1));
  assign accept     = (state == IDLE) && start && !abort && (num_samples != '0);
  assign flush      = abort && (state != IDLE);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = SYNC;
        SYNC:    if (tmr == 32'(SYNC_LEN - 1)) state_nx = SETTLE;
        SETTLE:  if (tmr == 32'(SETTLE_CYC - 1)) state_nx = CAPTURE;
        CAPTURE: if (last_push) state_nx = DRAIN;
        DRAIN:   if (pop && m_axis_tlast) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    ds            = (state == SYNC);
    busy          = (state != IDLE);
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (!fifo_empty) begin
      m_axis_tdata = mem[rd_ptr[AW-1:0]][DATA_W-1:0];
      m_axis_tlast = mem[rd_ptr[AW-1:0]][DATA_W];
    end
    state_dbg     = state;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      tmr       <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      demux     <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= (state == DRAIN) && pop && m_axis_tlast && !abort;
      if (state_nx != state || (state != SYNC && state != SETTLE)) tmr <= '0;
      else                                                         tmr <= tmr + 32'd1;
      if (accept) begin
        demux     <= demux_cfg;
        remaining <= num_samples;
        overflow  <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        remaining <= '0;
      end else begin
        if (push) begin
          wr_ptr    <= wr_ptr + 1'b1;
          remaining <= remaining - CNT_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the read side is gated by the empty flag.
  always_ff @(posedge aclk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= {last_push, s_tdata};
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: timed stimulus relative to the start edge,
// beat scoreboard, and per-scenario inline checks.
module tb_adc_capture_ctrl;

  logic        aclk = 1'b0;
  logic        rst;
  logic        start, abort, demux_cfg;
  logic [15:0] num_samples;
  logic        demux, ds;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy, done, overflow;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int done_cnt = 0;
  int done_edge = -1;
  int ds_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  adc_capture_ctrl #(
    .DATA_W(16), .CNT_W(16), .SYNC_LEN(4), .SETTLE_CYC(32), .FIFO_DEPTH(4)
  ) dut (
    .aclk(aclk), .rst(rst), .start(start), .abort(abort), .demux_cfg(demux_cfg),
    .num_samples(num_samples), .demux(demux), .ds(ds), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
    .done(done), .overflow(overflow), .state_dbg(state_dbg)
  );

  always #5 aclk = ~aclk;

  // Monitor on the falling edge: beats that will transfer on the next rising edge.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
    if (done) begin
      done_cnt++;
      done_edge = edge_n;
    end
    if (ds) ds_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    done_edge = -1;
    ds_cnt    = 0;
  endtask

  // Start sampled on edge 0; returns just after that edge.
  task automatic launch(input logic [15:0] n, input logic cfg);
    clear_mon();
    start = 1'b1; num_samples = n; demux_cfg = cfg;
    s_tvalid = 1'b1; s_tdata = 16'hF000;
    @(posedge aclk); #1;
    edge_n = 0;
    start = 1'b0;
  endtask

  // Drive inputs sampled at edge e, then advance past it. Capture opens at edge 37,
  // which receives sample value 1; earlier edges see marker values.
  task automatic step(input int e, input logic rdy, input logic vld);
    m_axis_tready = rdy;
    s_tvalid      = vld;
    s_tdata       = (e >= 37) ? 16'(e - 36) : (16'hF000 | 16'(e));
    @(posedge aclk); #1;
    edge_n = e;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; demux_cfg = 1'b0; num_samples = '0;
    s_tdata = '0; s_tvalid = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk); rst = 1'b0;
    tests++;
    if ({busy, ds, demux, done, overflow, m_axis_tvalid, m_axis_tlast} !== 7'b0 ||
        m_axis_tdata !== 16'h0 || state_dbg !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: outs=%b tdata=%h state=%0d, required all 0",
               {busy, ds, demux, done, overflow, m_axis_tvalid, m_axis_tlast}, m_axis_tdata, state_dbg);
    end
  endtask

  task automatic test_zero_samples();
    launch(16'd0, 1'b1);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b required 0", busy); end
    for (int e = 1; e <= 8; e++) step(e, 1'b1, 1'b1);
    tests++;
    if (ds_cnt != 0 || got_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_idle: ds_cycles=%0d beats=%0d busy=%b required 0/0/0", ds_cnt, got_q.size(), busy);
    end
  endtask

  task automatic test_normal();
    launch(16'd8, 1'b1);
    tests++;
    if (ds !== 1'b1 || busy !== 1'b1 || demux !== 1'b1) begin
      fails++; $display("FAIL normal_start: ds=%b busy=%b demux=%b required 1/1/1", ds, busy, demux);
    end
    for (int e = 1; e <= 50; e++) begin
      step(e, 1'b1, 1'b1);
      if (e == 36) begin
        tests++;
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL normal_early_valid: got %b required 0", m_axis_tvalid); end
      end
      if (e == 37) begin
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h1) begin
          fails++; $display("FAIL normal_first_beat: tvalid=%b tdata=%h required 1/0001", m_axis_tvalid, m_axis_tdata);
        end
      end
      if (e == 45) begin
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++; $display("FAIL normal_done: done=%b busy=%b required 1/0", done, busy);
        end
      end
    end
    for (int i = 1; i <= 8; i++) exp_q.push_back({(i == 8), 16'(i)});
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL normal_beat_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL normal_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    tests++;
    if (ds_cnt != 4 || done_cnt != 1 || done_edge != 45 || overflow !== 1'b0 || demux !== 1'b1) begin
      fails++;
      $display("FAIL normal_status: ds=%0d done_cnt=%0d done_edge=%0d ovf=%b demux=%b required 4/1/45/0/1",
               ds_cnt, done_cnt, done_edge, overflow, demux);
    end
  endtask

  task automatic test_stall_overflow();
    logic [15:0] vals [8];
    vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd11, 16'd12, 16'd13, 16'd14};
    launch(16'd8, 1'b1);
    for (int e = 1; e <= 60; e++) begin
      step(e, !(e >= 37 && e <= 46), 1'b1);
      if (e == 40 || e == 45) begin
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h1 || m_axis_tlast !== 1'b0) begin
          fails++; $display("FAIL stall_hold_e%0d: tvalid=%b tdata=%h tlast=%b required 1/0001/0",
                            e, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), vals[i]});
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stall_beat_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    tests++;
    if (overflow !== 1'b1 || done_cnt != 1 || done_edge != 54) begin
      fails++; $display("FAIL stall_status: ovf=%b done_cnt=%0d done_edge=%0d required 1/1/54", overflow, done_cnt, done_edge);
    end
  endtask

  task automatic test_full_pop();
    launch(16'd6, 1'b0);
    for (int e = 1; e <= 50; e++) step(e, !(e >= 37 && e <= 40), 1'b1);
    for (int i = 1; i <= 6; i++) exp_q.push_back({(i == 6), 16'(i)});
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL fullpop_beat_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL fullpop_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    tests++;
    if (overflow !== 1'b0 || done_edge != 46 || demux !== 1'b0) begin
      fails++; $display("FAIL fullpop_status: ovf=%b done_edge=%0d demux=%b required 0/46/0", overflow, done_edge, demux);
    end
  endtask

  task automatic test_single();
    launch(16'd1, 1'b1);
    for (int e = 1; e <= 42; e++) begin
      step(e, 1'b1, 1'b1);
      if (e == 37) begin
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== 16'h1) begin
          fails++; $display("FAIL single_beat: tvalid=%b tlast=%b tdata=%h required 1/1/0001",
                            m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
      end
    end
    tests++;
    if (got_q.size() != 1 || done_cnt != 1 || done_edge != 38) begin
      fails++; $display("FAIL single_status: beats=%0d done_cnt=%0d done_edge=%0d required 1/1/38",
                        got_q.size(), done_cnt, done_edge);
    end
  endtask

  task automatic test_abort();
    launch(16'd5, 1'b1);
    for (int e = 1; e <= 45; e++) begin
      start       = (e == 38);
      num_samples = (e == 38) ? 16'd3 : 16'd5;
      abort       = (e == 39);
      step(e, 1'b0, (e <= 38));
      start = 1'b0; abort = 1'b0;
      if (e == 38) begin
        tests++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || state_dbg !== 3'd3) begin
          fails++; $display("FAIL abort_pending: tvalid=%b busy=%b state=%0d required 1/1/3", m_axis_tvalid, busy, state_dbg);
        end
      end
      if (e == 39) begin
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ds !== 1'b0) begin
          fails++; $display("FAIL abort_effect: tvalid=%b busy=%b done=%b ds=%b required 0/0/0/0",
                            m_axis_tvalid, busy, done, ds);
        end
      end
    end
    tests++;
    if (done_cnt != 0 || got_q.size() != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL abort_after: done_cnt=%0d beats=%0d busy=%b ovf=%b required 0/0/0/0",
                        done_cnt, got_q.size(), busy, overflow);
    end
  endtask

  task automatic test_reset_mid_capture();
    launch(16'd8, 1'b1);
    for (int e = 1; e <= 40; e++) step(e, !(e >= 37), 1'b1);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, ds, demux, done, overflow, m_axis_tvalid, m_axis_tlast} !== 7'b0 || m_axis_tdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_capture: outs=%b tdata=%h required all 0",
               {busy, ds, demux, done, overflow, m_axis_tvalid, m_axis_tlast}, m_axis_tdata);
    end
    @(negedge aclk); rst = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_samples();
    test_normal();
    test_stall_overflow();
    test_full_pop();
    test_single();
    test_abort();
    test_reset_mid_capture();
    test_normal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
